sub_div_ctrl: RTL and testbench

Iterative unsigned restoring divider. It sequences a single ripple-borrow subtractor over W cycles to produce quotient and remainder. It sits beside the team's subtractor datapath as its controller, with valid/ready handshakes on both sides. Use it where a divide is needed but a full array divider is too large.

---
 rtl/sub_div_ctrl_pkg.sv | 12 +
 rtl/sub_borrow_w.sv | 23 ++
 rtl/sub_div_ctrl.sv | 102 ++++++++++
 tb/tb_sub_div_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/sub_div_ctrl_pkg.sv
// rtl/sub_div_ctrl_pkg.sv - shared state encoding and default width for the iterative divider
package sub_div_ctrl_pkg;

  localparam int DEF_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/sub_borrow_w.sv
// rtl/sub_borrow_w.sv - N-bit ripple-borrow subtractor built from 1-bit full-subtractor cells
module sub_borrow_w #(
  parameter int N = 9
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  output logic [N-1:0] d,
  output logic         bout
);

  logic [N:0] br;

  assign br[0] = bin;

  for (genvar i = 0; i < N; i++) begin : g_cell
    assign d[i]    = a[i] ^ b[i] ^ br[i];
    assign br[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br[i]);
  end

  assign bout = br[N];

endmodule

// File: rtl/sub_div_ctrl.sv
// rtl/sub_div_ctrl.sv - restoring divider controller; one subtractor reused over W cycles
module sub_div_ctrl
  import sub_div_ctrl_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         div_by_zero,
  output logic         busy
);

  localparam int CW = (W > 2) ? $clog2(W) : 1;

  div_state_t    state;
  logic [W-1:0]  q;
  logic [W-1:0]  p;
  logic [W-1:0]  dreg;
  logic [CW-1:0] cnt;
  logic          dbz;

  logic [W:0]    s_val;
  logic [W:0]    diff;
  logic          bout;
  logic          unused_diff_msb;

  // Partial remainder with the next dividend bit shifted in
  assign s_val = {p, q[W-1]};

  sub_borrow_w #(.N(W + 1)) u_sub (
    .a    (s_val),
    .b    ({1'b0, dreg}),
    .bin  (1'b0),
    .d    (diff),
    .bout (bout)
  );

  // No borrow implies diff < dreg, so the top bit is always zero when used
  assign unused_diff_msb = diff[W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      q     <= '0;
      p     <= '0;
      dreg  <= '0;
      cnt   <= '0;
      dbz   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            dreg <= divisor;
            cnt  <= CW'(W - 1);
            if (divisor == '0) begin
              q     <= '1;
              p     <= dividend;
              dbz   <= 1'b1;
              state <= DONE;
            end else begin
              q     <= dividend;
              p     <= '0;
              dbz   <= 1'b0;
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (!bout) begin
            p <= diff[W-1:0];
            q <= {q[W-2:0], 1'b1};
          end else begin
            p <= s_val[W-1:0];
            q <= {q[W-2:0], 1'b0};
          end
          cnt <= cnt - 1'b1;
          if (cnt == '0) state <= DONE;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready    = (state == IDLE);
  assign out_valid   = (state == DONE);
  assign busy        = (state != IDLE);
  assign quotient    = q;
  assign remainder   = p;
  assign div_by_zero = dbz;

endmodule

// File: tb/tb_sub_div_ctrl.sv
// tb/tb_sub_div_ctrl.sv - directed and random checks of the iterative divider
module tb_sub_div_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;
  logic         busy;

  int errors = 0;
  int checks = 0;

  sub_div_ctrl #(.W(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands and step through the accepting edge
  task automatic start(input logic [W-1:0] a, input logic [W-1:0] b, input bit hold);
    int n;
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 40) begin
      tick();
      n++;
    end
    tick();
    if (!hold) in_valid = 1'b0;
  endtask

  // Edges after the accepting edge until out_valid is seen
  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  initial begin
    int lat;
    logic [W-1:0] a, b, eq, er;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    dividend  = '0;
    divisor   = '0;

    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_quotient", quotient, 0);
    check("rst_remainder", remainder, 0);
    check("rst_dbz", div_by_zero, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // 200 / 7
    start(8'd200, 8'd7, 1'b0);
    check("200_7_busy", busy, 1);
    check("200_7_in_ready", in_ready, 0);
    wait_done(lat);
    check("200_7_lat", lat, 8);
    check("200_7_q", quotient, 28);
    check("200_7_r", remainder, 4);
    check("200_7_dbz", div_by_zero, 0);
    tick();
    check("200_7_in_ready_after", in_ready, 1);
    check("200_7_out_valid_after", out_valid, 0);

    // Back-to-back corner operands with in_valid held high
    start(8'd255, 8'd1, 1'b1);
    dividend = 8'd5;
    divisor  = 8'd9;
    wait_done(lat);
    check("255_1_lat", lat, 8);
    check("255_1_q", quotient, 255);
    check("255_1_r", remainder, 0);
    check("255_1_in_ready", in_ready, 0);
    tick();
    check("b2b_idle_only", in_ready, 1);
    check("b2b_idle_q_held", quotient, 255);
    tick();
    check("5_9_accepted", busy, 1);
    dividend = 8'd255;
    divisor  = 8'd255;
    wait_done(lat);
    check("5_9_lat", lat, 8);
    check("5_9_q", quotient, 0);
    check("5_9_r", remainder, 5);
    tick();
    check("b2b_idle2", in_ready, 1);
    tick();
    in_valid = 1'b0;
    wait_done(lat);
    check("255_255_lat", lat, 8);
    check("255_255_q", quotient, 1);
    check("255_255_r", remainder, 0);
    tick();

    // Divide by zero
    start(8'd100, 8'd0, 1'b0);
    wait_done(lat);
    check("100_0_lat", lat, 0);
    check("100_0_out_valid", out_valid, 1);
    check("100_0_q", quotient, 255);
    check("100_0_r", remainder, 100);
    check("100_0_dbz", div_by_zero, 1);
    tick();
    check("100_0_in_ready_after", in_ready, 1);

    // Back-pressure, with a new request arriving while busy
    out_ready = 1'b0;
    start(8'd77, 8'd6, 1'b0);
    dividend = 8'd9;
    divisor  = 8'd3;
    in_valid = 1'b1;
    wait_done(lat);
    check("77_6_lat", lat, 8);
    for (int i = 0; i < 3; i++) begin
      check("77_6_hold_valid", out_valid, 1);
      check("77_6_hold_q", quotient, 12);
      check("77_6_hold_r", remainder, 5);
      check("77_6_hold_in_ready", in_ready, 0);
      tick();
    end
    check("77_6_still_done", out_valid, 1);
    out_ready = 1'b1;
    tick();
    check("77_6_to_idle", in_ready, 1);
    tick();
    in_valid = 1'b0;
    wait_done(lat);
    check("9_3_lat", lat, 8);
    check("9_3_q", quotient, 3);
    check("9_3_r", remainder, 0);
    tick();

    // Asynchronous reset part way through an operation
    start(8'd200, 8'd7, 1'b0);
    for (int i = 0; i < 3; i++) tick();
    #2;
    rst = 1'b1;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_in_ready", in_ready, 1);
    check("arst_busy", busy, 0);
    check("arst_q", quotient, 0);
    check("arst_r", remainder, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    start(8'd9, 8'd3, 1'b0);
    wait_done(lat);
    check("post_rst_lat", lat, 8);
    check("post_rst_q", quotient, 3);
    check("post_rst_r", remainder, 0);
    tick();

    // Random operands against a reference division
    for (int i = 0; i < 1000; i++) begin
      a = W'($urandom_range(0, 255));
      b = ($urandom_range(0, 15) == 0) ? '0 : W'($urandom_range(1, 255));
      if (b == '0) begin
        eq = '1;
        er = a;
      end else begin
        eq = a / b;
        er = a % b;
      end
      start(a, b, 1'b0);
      wait_done(lat);
      check("rnd_lat", lat, (b == '0) ? 0 : 8);
      check("rnd_q", quotient, eq);
      check("rnd_r", remainder, er);
      check("rnd_dbz", div_by_zero, (b == '0) ? 1 : 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
